// File: rtl/dac_pkg.sv
// Shared types and the per-update ramp rule for the sigma-delta DAC scheduler.
// The ramp helper works at RAMP_W bits; callers zero-extend and truncate back.
package dac_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } dac_state_e;

    localparam int RAMP_W = 16;

    // Result always lies between cur and tgt, so truncating to the caller's width is lossless.
    function automatic logic [RAMP_W-1:0] ramp_next(
        input logic [RAMP_W-1:0] cur,
        input logic [RAMP_W-1:0] tgt,
        input logic [RAMP_W-1:0] step
    );
        logic [RAMP_W-1:0] d;
        d = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if ((step == {RAMP_W{1'b0}}) || (d <= step)) begin
            ramp_next = tgt;
        end else if (tgt > cur) begin
            ramp_next = cur + step;
        end else begin
            ramp_next = cur - step;
        end
    endfunction

endpackage

// File: rtl/dac_sched_if.sv
// Setpoint write channel into the DAC scheduler (valid/ready handshake).
interface dac_sched_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CW-1:0]    wr_chan;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_chan, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_chan, input wr_data, output wr_ready);
endinterface

// File: rtl/dac_prescaler.sv
// Programmable prescaler producing the registered one-cycle DAC update strobe.
module dac_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_WIDTH-1:0] i_cfg_div,
    output logic                 o_ena
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_ena;

    // Compare with >= so a divider lowered below the count fires at once instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {DIV_WIDTH{1'b0}};
            r_ena <= 1'b0;
        end else if (r_cnt >= i_cfg_div) begin
            r_cnt <= {DIV_WIDTH{1'b0}};
            r_ena <= 1'b1;
        end else begin
            r_cnt <= r_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            r_ena <= 1'b0;
        end
    end

    assign o_ena = r_ena;

endmodule

// File: rtl/dac_sched.sv
// Multi-channel DAC scheduler: setpoint writes, shared update strobe, and a
// per-tick round-robin scan that slew-limits each channel toward its target.
module dac_sched
    import dac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 16,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [DIV_WIDTH-1:0]      i_cfg_div,
    input  logic [WIDTH-1:0]          i_cfg_step,
    dac_sched_if.slave                wr_if,
    input  logic                      i_ovr_clr,
    output logic                      o_dac_ena,
    output logic [CHANNELS*WIDTH-1:0] o_dac_data,
    output logic [CHANNELS-1:0]       o_busy,
    output logic                      o_overrun
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SCAN = SCAN;

    logic                w_ena;
    logic                w_accept;
    logic [0:0]          r_state,  w_state_nxt;
    logic [CW-1:0]       r_idx,    w_idx_nxt;
    logic                r_ovr,    w_ovr_nxt;
    logic                r_wr_ready;
    logic [CHANNELS-1:0] r_busy,   w_busy_nxt;
    logic [WIDTH-1:0]    r_tgt [CHANNELS];
    logic [WIDTH-1:0]    r_cur [CHANNELS];
    logic [WIDTH-1:0]    w_tgt_nxt [CHANNELS];
    logic [WIDTH-1:0]    w_cur_nxt [CHANNELS];

    dac_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cfg_div (i_cfg_div),
        .o_ena     (w_ena)
    );

    assign w_accept = wr_if.wr_valid & r_wr_ready;

    // Next-state logic: scan FSM, ramping of the scanned channel, target writes, overrun.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            ST_IDLE: begin
                if (w_ena) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                w_cur_nxt[r_idx] = WIDTH'(ramp_next(RAMP_W'(r_cur[r_idx]),
                                                    RAMP_W'(r_tgt[r_idx]),
                                                    RAMP_W'(i_cfg_step)));
                if (r_idx == CW'(CHANNELS-1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = {CW{1'b0}};
            end
        endcase

        // Out-of-range channel numbers match no slot, so such writes are accepted and dropped.
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_accept && (int'(wr_if.wr_chan) == k)) begin
                w_tgt_nxt[k] = wr_if.wr_data;
            end else begin
                w_tgt_nxt[k] = r_tgt[k];
            end
        end

        for (int k = 0; k < CHANNELS; k++) begin
            w_busy_nxt[k] = (w_cur_nxt[k] != w_tgt_nxt[k]);
        end

        if (w_ena && (r_state == ST_SCAN)) begin
            w_ovr_nxt = 1'b1;
        end else if (i_ovr_clr) begin
            w_ovr_nxt = 1'b0;
        end else begin
            w_ovr_nxt = r_ovr;
        end
    end

    // State registers; ready is registered from the next state so it tracks IDLE exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= {CW{1'b0}};
            r_ovr      <= 1'b0;
            r_wr_ready <= 1'b0;
            r_busy     <= {CHANNELS{1'b0}};
            for (int k = 0; k < CHANNELS; k++) begin
                r_tgt[k] <= {WIDTH{1'b0}};
                r_cur[k] <= {WIDTH{1'b0}};
            end
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_ovr      <= w_ovr_nxt;
            r_wr_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= w_busy_nxt;
            r_tgt      <= w_tgt_nxt;
            r_cur      <= w_cur_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_data
            assign o_dac_data[g*WIDTH +: WIDTH] = r_cur[g];
        end
    endgenerate

    assign wr_if.wr_ready = r_wr_ready;
    assign o_dac_ena      = w_ena;
    assign o_busy         = r_busy;
    assign o_overrun      = r_ovr;

endmodule

// File: tb/tb_dac_sched.sv
// Self-checking bench for dac_sched: ramp-rule vector table, directed corner
// sequences, and a randomized run checked every cycle against a behavioural model.
module tb_dac_sched;
    import dac_pkg::*;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 4;
    localparam int DIV_WIDTH = 16;
    localparam int CW        = 2;

    logic                      clk;
    logic                      rst;
    logic [DIV_WIDTH-1:0]      cfg_div;
    logic [WIDTH-1:0]          cfg_step;
    logic                      ovr_clr;
    logic                      dac_ena;
    logic [CHANNELS*WIDTH-1:0] dac_data;
    logic [CHANNELS-1:0]       busy;
    logic                      overrun;

    dac_sched_if #(.WIDTH(WIDTH), .CW(CW)) wr_bus ();

    dac_sched #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_div  (cfg_div),
        .i_cfg_step (cfg_step),
        .wr_if      (wr_bus),
        .i_ovr_clr  (ovr_clr),
        .o_dac_ena  (dac_ena),
        .o_dac_data (dac_data),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass;
    int n_total;
    int cyc_n;

    // Behavioural model: scan position is just "scanning, at channel m_idx".
    int m_cnt, m_idx;
    bit m_ena, m_scan, m_ovr, m_ready;
    int m_tgt [CHANNELS];
    int m_cur [CHANNELS];

    typedef struct {
        logic [15:0] cur;
        logic [15:0] tgt;
        logic [15:0] step;
        logic [15:0] exp;
    } ramp_vec_t;

    task automatic chk(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_ramp(int c, int t, int s);
        int d;
        d = (t > c) ? t - c : c - t;
        if (s == 0 || d <= s) return t;
        return (t > c) ? c + s : c - s;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_ena = 0; m_scan = 0; m_ovr = 0; m_ready = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            m_tgt[k] = 0;
            m_cur[k] = 0;
        end
    endtask

    task automatic model_step();
        bit acc, ena_n, scan_n, ovr_n;
        int cnt_n, idx_n;
        if (rst) begin
            model_reset();
            return;
        end
        acc    = wr_bus.wr_valid && m_ready;
        ena_n  = (m_cnt >= int'(cfg_div));
        cnt_n  = ena_n ? 0 : m_cnt + 1;
        scan_n = m_scan;
        idx_n  = m_idx;
        ovr_n  = (m_scan && m_ena) ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
        if (m_scan) begin
            m_cur[m_idx] = ref_ramp(m_cur[m_idx], m_tgt[m_idx], int'(cfg_step));
            if (m_idx == CHANNELS - 1) scan_n = 0;
            else idx_n = m_idx + 1;
        end else if (m_ena) begin
            scan_n = 1;
            idx_n  = 0;
        end
        if (acc && int'(wr_bus.wr_chan) < CHANNELS) m_tgt[int'(wr_bus.wr_chan)] = int'(wr_bus.wr_data);
        m_cnt = cnt_n; m_ena = ena_n; m_scan = scan_n; m_idx = idx_n; m_ovr = ovr_n;
        m_ready = !scan_n;
    endtask

    task automatic chk_all();
        logic [CHANNELS*WIDTH-1:0] exp_data;
        logic [CHANNELS-1:0]       exp_busy;
        for (int k = 0; k < CHANNELS; k++) begin
            exp_data[k*WIDTH +: WIDTH] = WIDTH'(m_cur[k]);
            exp_busy[k] = (m_cur[k] != m_tgt[k]);
        end
        chk("dac_ena",  dac_ena,         m_ena);
        chk("wr_ready", wr_bus.wr_ready, m_ready);
        chk("dac_data", dac_data,        exp_data);
        chk("busy",     busy,            exp_busy);
        chk("overrun",  overrun,         m_ovr);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        chk_all();
    endtask

    task automatic wait_ena();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc();
            seen = dac_ena;
        end
        chk("ena_seen", seen, 1);
    endtask

    task automatic do_write(int ch, int d);
        bit acc;
        acc = 0;
        wr_bus.wr_chan  = CW'(ch);
        wr_bus.wr_data  = WIDTH'(d);
        wr_bus.wr_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = wr_bus.wr_ready;
            cyc();
        end
        wr_bus.wr_valid = 1'b0;
        chk("write_accept", acc, 1);
    endtask

    initial begin
        ramp_vec_t vecs [10];
        int last, npulse, nlow, first_hi, t_ena;
        logic [7:0] ramp_exp [8];

        n_pass = 0; n_total = 0; cyc_n = 0;
        rst = 1'b1; cfg_div = 16'd9; cfg_step = 8'd0; ovr_clr = 1'b0;
        wr_bus.wr_valid = 1'b0; wr_bus.wr_chan = 2'd0; wr_bus.wr_data = 8'd0;
        model_reset();

        vecs[0] = '{16'h0000, 16'h0035, 16'h0010, 16'h0010};
        vecs[1] = '{16'h0030, 16'h0035, 16'h0010, 16'h0035};
        vecs[2] = '{16'h0035, 16'h0000, 16'h0010, 16'h0025};
        vecs[3] = '{16'h0005, 16'h0000, 16'h0010, 16'h0000};
        vecs[4] = '{16'h0000, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[5] = '{16'h00F0, 16'h00FF, 16'h0020, 16'h00FF};
        vecs[6] = '{16'h00FF, 16'h0000, 16'h0001, 16'h00FE};
        vecs[7] = '{16'h0010, 16'h0010, 16'h0005, 16'h0010};
        vecs[8] = '{16'h0080, 16'h0000, 16'h0080, 16'h0000};
        vecs[9] = '{16'h0001, 16'h00FF, 16'h00FE, 16'h00FF};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ramp_vec%0d", i), ramp_next(vecs[i].cur, vecs[i].tgt, vecs[i].step), vecs[i].exp);
        end

        // Reset held: everything zero, not ready.
        repeat (3) cyc();
        chk("rst_ready", wr_bus.wr_ready, 0);
        chk("rst_data",  dac_data, 0);
        rst = 1'b0;

        // cfg_div=9: strobe every 10 cycles.
        last = -1; npulse = 0;
        for (int i = 0; i < 45; i++) begin
            cyc();
            if (dac_ena) begin
                if (last >= 0) chk("ena_period", cyc_n - last, 10);
                last = cyc_n;
                npulse++;
            end
        end
        chk("ena_pulses", npulse, 4);

        // No slew limit: ch2 := C8 lands in one scan.
        wait_ena(); repeat (5) cyc();
        do_write(2, 8'hC8);
        chk("busy2_rise", busy[2], 1);
        wait_ena(); repeat (4) cyc();
        chk("ch2_code", dac_data[2*WIDTH +: WIDTH], 8'hC8);
        chk("other_codes", {dac_data[3*WIDTH +: WIDTH], dac_data[WIDTH-1:0], dac_data[WIDTH +: WIDTH]}, 0);
        chk("busy2_fall", busy, 0);

        // Slew limited ramp up and back down on ch0.
        cfg_step = 8'h10;
        ramp_exp[0] = 8'h10; ramp_exp[1] = 8'h20; ramp_exp[2] = 8'h30; ramp_exp[3] = 8'h35;
        ramp_exp[4] = 8'h25; ramp_exp[5] = 8'h15; ramp_exp[6] = 8'h05; ramp_exp[7] = 8'h00;
        wait_ena(); repeat (5) cyc();
        do_write(0, 8'h35);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) do_write(0, 8'h00);
            wait_ena(); repeat (2) cyc();
            chk($sformatf("ramp_step%0d", i), dac_data[WIDTH-1:0], ramp_exp[i]);
        end

        // Write held across a tick: ready low for CHANNELS cycles, accepted right after.
        wait_ena(); repeat (5) cyc();
        wait_ena();
        t_ena = cyc_n;
        cyc();
        wr_bus.wr_chan = 2'd1; wr_bus.wr_data = 8'hFF; wr_bus.wr_valid = 1'b1;
        nlow = (wr_bus.wr_ready == 1'b0) ? 1 : 0;
        first_hi = -1;
        for (int i = 0; i < 20 && first_hi < 0; i++) begin
            cyc();
            if (wr_bus.wr_ready) first_hi = cyc_n;
            else nlow++;
        end
        chk("ready_low_cycles", nlow, CHANNELS);
        chk("ready_return", first_hi - t_ena, CHANNELS + 1);
        cyc();
        wr_bus.wr_valid = 1'b0;
        chk("held_write_busy", busy[1], 1);

        // Overrun with cfg_div=1: sets, sticks, then clears on a quiet ovr_clr.
        cfg_div = 16'd1;
        nlow = 0;
        for (int i = 0; i < 40 && !overrun; i++) cyc();
        chk("ovr_set", overrun, 1);
        repeat (8) cyc();
        chk("ovr_sticky", overrun, 1);
        cfg_div = 16'd100;
        repeat (10) cyc();
        ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Reset mid-scan after loading all channels.
        cfg_div = 16'd9; cfg_step = 8'd0;
        for (int k = 0; k < CHANNELS; k++) do_write(k, 8'h80);
        wait_ena(); repeat (2) cyc();
        chk("pre_rst_ch0", dac_data[WIDTH-1:0], 8'h80);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_data",  dac_data, 0);
        chk("async_rst_busy",  busy, 0);
        chk("async_rst_ready", wr_bus.wr_ready, 0);
        chk("async_rst_ena",   dac_ena, 0);
        repeat (2) cyc();
        rst = 1'b0;
        wait_ena(); repeat (5) cyc();
        chk("post_rst_data", dac_data, 0);

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) cfg_div = DIV_WIDTH'($urandom_range(0, 12));
            if (i % 37 == 0)  cfg_step = WIDTH'($urandom_range(0, 255));
            wr_bus.wr_valid = ($urandom_range(0, 1) == 1);
            wr_bus.wr_chan  = CW'($urandom_range(0, CHANNELS - 1));
            wr_bus.wr_data  = WIDTH'($urandom_range(0, 255));
            ovr_clr         = ($urandom_range(0, 15) == 0);
            cyc();
        end
        wr_bus.wr_valid = 1'b0;
        ovr_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
